// File: rtl/cu_arb.sv
// Round-robin arbiter that time-shares one combinational decode unit between
// NREQ requesters and returns each decoded result through a valid/ready response.
module cu_arb #(
    parameter int NREQ = 4,
    parameter int OPW  = 14,
    parameter int RESW = 11
) (
    input  logic                     clk_pad,
    input  logic                     rst_pad,
    input  logic [NREQ-1:0]          req_pad,
    input  logic [NREQ*OPW-1:0]      op_pad,
    output logic [NREQ-1:0]          gnt_pad,
    output logic [OPW-1:0]           dec_in_pad,
    input  logic [RESW-1:0]          dec_out_pad,
    output logic                     rsp_vld_pad,
    output logic [$clog2(NREQ)-1:0]  rsp_id_pad,
    output logic [RESW-1:0]          rsp_dat_pad,
    input  logic                     rsp_rdy_pad,
    output logic                     busy_pad,
    output logic [7:0]               cnt_pad
);

    // state | meaning
    // IDLE  | waiting for a request; grant decided on the next edge
    // ISSUE | gnt_pad high for one cycle; decoder evaluates op_q
    // HOLD  | response presented until rsp_rdy_pad is sampled high
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int IDW = $clog2(NREQ);

    state_t          state;
    logic [OPW-1:0]  op_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  ptr;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [OPW-1:0]  win_op;
    logic [NREQ-1:0] win_onehot;

    // Search starts one past the last served requester so service rotates.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!win_found && req_pad[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
        win_op     = op_pad[win_idx*OPW +: OPW];
        win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end

    assign dec_in_pad = op_q;

    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            state       <= IDLE;
            gnt_pad     <= '0;
            op_q        <= '0;
            id_q        <= '0;
            ptr         <= IDW'(NREQ - 1);
            rsp_vld_pad <= 1'b0;
            rsp_id_pad  <= '0;
            rsp_dat_pad <= '0;
            busy_pad    <= 1'b0;
            cnt_pad     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_q     <= win_op;
                        id_q     <= win_idx;
                        gnt_pad  <= win_onehot;
                        busy_pad <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        gnt_pad  <= '0;
                    end
                end
                ISSUE: begin
                    rsp_dat_pad <= dec_out_pad;
                    rsp_id_pad  <= id_q;
                    rsp_vld_pad <= 1'b1;
                    gnt_pad     <= '0;
                    state       <= HOLD;
                end
                HOLD: begin
                    // Always pass through IDLE so grants are at least 3 cycles apart.
                    if (rsp_rdy_pad) begin
                        rsp_vld_pad <= 1'b0;
                        ptr         <= id_q;
                        cnt_pad     <= cnt_pad + 8'd1;
                        busy_pad    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    gnt_pad     <= '0;
                    rsp_vld_pad <= 1'b0;
                    busy_pad    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_arb.sv
// Directed self-checking bench for cu_arb with a small combinational decoder model
// attached to dec_in_pad/dec_out_pad.
module tb_cu_arb;

    localparam int NREQ = 4;
    localparam int OPW  = 14;
    localparam int RESW = 11;

    logic                 clk_pad;
    logic                 rst_pad;
    logic [NREQ-1:0]      req_pad;
    logic [NREQ*OPW-1:0]  op_pad;
    logic [NREQ-1:0]      gnt_pad;
    logic [OPW-1:0]       dec_in_pad;
    logic [RESW-1:0]      dec_out_pad;
    logic                 rsp_vld_pad;
    logic [1:0]           rsp_id_pad;
    logic [RESW-1:0]      rsp_dat_pad;
    logic                 rsp_rdy_pad;
    logic                 busy_pad;
    logic [7:0]           cnt_pad;

    int total = 0;
    int bad   = 0;

    cu_arb #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW)) dut (
        .clk_pad     (clk_pad),
        .rst_pad     (rst_pad),
        .req_pad     (req_pad),
        .op_pad      (op_pad),
        .gnt_pad     (gnt_pad),
        .dec_in_pad  (dec_in_pad),
        .dec_out_pad (dec_out_pad),
        .rsp_vld_pad (rsp_vld_pad),
        .rsp_id_pad  (rsp_id_pad),
        .rsp_dat_pad (rsp_dat_pad),
        .rsp_rdy_pad (rsp_rdy_pad),
        .busy_pad    (busy_pad),
        .cnt_pad     (cnt_pad)
    );

    function automatic logic [RESW-1:0] dec_fn(input logic [OPW-1:0] op);
        return op[10:0] ^ {op[13:11], 8'h5A};
    endfunction

    assign dec_out_pad = dec_fn(dec_in_pad);

    initial begin
        clk_pad = 1'b0;
        forever #5 clk_pad = ~clk_pad;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pad);
        #1;
    endtask

    task automatic set_op(input int i, input logic [OPW-1:0] v);
        op_pad[i*OPW +: OPW] = v;
    endtask

    task automatic do_reset();
        rst_pad     = 1'b1;
        req_pad     = '0;
        rsp_rdy_pad = 1'b0;
        repeat (2) tick();
        rst_pad     = 1'b0;
    endtask

    logic [OPW-1:0]  ops [NREQ];
    logic [1:0]      held_id;
    logic [RESW-1:0] held_dat;

    initial begin
        rst_pad     = 1'b1;
        req_pad     = '0;
        op_pad      = '0;
        rsp_rdy_pad = 1'b0;
        #2;
        chk("rst_gnt",  32'(gnt_pad), 32'h0);
        chk("rst_vld",  32'(rsp_vld_pad), 32'h0);
        chk("rst_cnt",  32'(cnt_pad), 32'h0);
        chk("rst_busy", 32'(busy_pad), 32'h0);
        chk("rst_dec",  32'(dec_in_pad), 32'h0);
        do_reset();

        // single request
        req_pad = 4'b0001; set_op(0, 14'h00A5); rsp_rdy_pad = 1'b1;
        tick();
        chk("s_gnt",  32'(gnt_pad), 32'h1);
        chk("s_busy", 32'(busy_pad), 32'h1);
        chk("s_dec",  32'(dec_in_pad), 32'h0A5);
        req_pad = '0;
        tick();
        chk("s_gnt_off", 32'(gnt_pad), 32'h0);
        chk("s_vld", 32'(rsp_vld_pad), 32'h1);
        chk("s_id",  32'(rsp_id_pad), 32'h0);
        chk("s_dat", 32'(rsp_dat_pad), 32'h0FF);
        tick();
        chk("s_vld_off", 32'(rsp_vld_pad), 32'h0);
        chk("s_cnt",  32'(cnt_pad), 32'h1);
        chk("s_idle", 32'(busy_pad), 32'h0);

        // all four continuously: grants 0,1,2,3,0 every 3 cycles
        do_reset();
        ops[0] = 14'h0011; ops[1] = 14'h0222; ops[2] = 14'h1333; ops[3] = 14'h3AAA;
        for (int i = 0; i < NREQ; i++) set_op(i, ops[i]);
        req_pad = 4'b1111; rsp_rdy_pad = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            chk($sformatf("rr_gnt_c%0d", c), 32'(gnt_pad),
                (c % 3 == 0) ? (32'h1 << ((c / 3) % 4)) : 32'h0);
            if (c % 3 == 1) begin
                chk($sformatf("rr_id_c%0d", c), 32'(rsp_id_pad), 32'((c / 3) % 4));
                chk($sformatf("rr_dat_c%0d", c), 32'(rsp_dat_pad), 32'(dec_fn(ops[(c / 3) % 4])));
            end
        end
        req_pad = '0;
        chk("rr_cnt", 32'(cnt_pad), 32'd5);

        // backpressure: ptr=0, only requester 2 asks
        req_pad = 4'b0100; rsp_rdy_pad = 1'b0;
        tick();
        chk("bp_gnt", 32'(gnt_pad), 32'h4);
        req_pad = 4'b1111;
        tick();
        chk("bp_vld", 32'(rsp_vld_pad), 32'h1);
        chk("bp_id",  32'(rsp_id_pad), 32'h2);
        chk("bp_dat", 32'(rsp_dat_pad), 32'(dec_fn(14'h1333)));
        held_id = rsp_id_pad; held_dat = rsp_dat_pad;
        for (int c = 0; c < 10; c++) begin
            set_op(2, 14'(c * 14'h0321));
            tick();
            chk($sformatf("bp_hold_vld%0d", c), 32'(rsp_vld_pad), 32'h1);
            chk($sformatf("bp_hold_id%0d", c),  32'(rsp_id_pad), 32'(held_id));
            chk($sformatf("bp_hold_dat%0d", c), 32'(rsp_dat_pad), 32'(held_dat));
            chk($sformatf("bp_hold_gnt%0d", c), 32'(gnt_pad), 32'h0);
            chk($sformatf("bp_hold_busy%0d", c), 32'(busy_pad), 32'h1);
        end
        rsp_rdy_pad = 1'b1; req_pad = '0;
        tick();
        chk("bp_rel_vld",  32'(rsp_vld_pad), 32'h0);
        chk("bp_rel_busy", 32'(busy_pad), 32'h0);
        chk("bp_rel_cnt",  32'(cnt_pad), 32'd6);

        // opcode changes during ISSUE must not leak (ptr=2 -> winner 0)
        req_pad = 4'b0001; set_op(0, 14'h1234);
        tick();
        chk("op_gnt", 32'(gnt_pad), 32'h1);
        chk("op_dec", 32'(dec_in_pad), 32'h1234);
        set_op(0, 14'h3FFF); req_pad = '0;
        tick();
        chk("op_dat", 32'(rsp_dat_pad), 32'h06E);
        chk("op_id",  32'(rsp_id_pad), 32'h0);
        tick();
        chk("op_cnt", 32'(cnt_pad), 32'd7);

        // request withdrawn before sampling
        req_pad = 4'b0010;
        #2;
        req_pad = '0;
        tick();
        chk("drop_gnt",  32'(gnt_pad), 32'h0);
        chk("drop_busy", 32'(busy_pad), 32'h0);

        // reset in HOLD aborts the response and restores requester-0 priority
        req_pad = 4'b0001; rsp_rdy_pad = 1'b0;
        tick();
        chk("ab_gnt", 32'(gnt_pad), 32'h1);
        req_pad = '0;
        tick();
        chk("ab_vld", 32'(rsp_vld_pad), 32'h1);
        tick();
        #2;
        rst_pad = 1'b1;
        #1;
        chk("ab_vld_async", 32'(rsp_vld_pad), 32'h0);
        chk("ab_cnt",  32'(cnt_pad), 32'h0);
        chk("ab_busy", 32'(busy_pad), 32'h0);
        chk("ab_dec",  32'(dec_in_pad), 32'h0);
        #1;
        rst_pad = 1'b0; req_pad = 4'b1111; rsp_rdy_pad = 1'b1;
        tick();
        chk("ab_first_gnt", 32'(gnt_pad), 32'h1);
        req_pad = '0;
        repeat (2) tick();
        chk("ab_cnt_after", 32'(cnt_pad), 32'd1);

        // counter wrap after 256 responses
        do_reset();
        req_pad = 4'b0001; rsp_rdy_pad = 1'b1;
        repeat (255 * 3) tick();
        chk("wrap_255", 32'(cnt_pad), 32'd255);
        repeat (3) tick();
        req_pad = '0;
        chk("wrap_0", 32'(cnt_pad), 32'd0);
        tick();
        chk("wrap_vld",  32'(rsp_vld_pad), 32'h0);
        chk("wrap_busy", 32'(busy_pad), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_arb.md
CU_ARB -- requirements
Module: cu_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the decode unit (2..8).
REQ-002 Parameter OPW, default 14, SHALL set the opcode width presented to the shared decoder.
REQ-003 Parameter RESW, default 11, SHALL set the decoder result width.
REQ-004 clk_pad  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_pad  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req_pad  input  NREQ  SHALL carry the per-requester request bits.
REQ-007 op_pad  input  NREQ*OPW  SHALL carry the opcodes; slice i (bits i*OPW +: OPW) belongs to requester i.
REQ-008 gnt_pad  output  NREQ  SHALL carry the registered, one-hot grant pulse.
REQ-009 dec_in_pad  output  OPW  SHALL drive the shared combinational decoder input from a register.
REQ-010 dec_out_pad  input  RESW  SHALL receive the decoder result, combinational from dec_in_pad in the same cycle.
REQ-011 rsp_vld_pad  output  1  SHALL indicate that a response is valid.
REQ-012 rsp_id_pad  output  clog2(NREQ)  SHALL carry the index of the requester that owns the response.
REQ-013 rsp_dat_pad  output  RESW  SHALL carry the captured decoder result.
REQ-014 rsp_rdy_pad  input  1  SHALL indicate that the response consumer accepts the response.
REQ-015 busy_pad  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-016 cnt_pad  output  8  SHALL count completed responses.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE and HOLD, and all outputs SHALL be driven from registers.
REQ-018 In IDLE, when any req_pad bit is set at a rising edge, the block SHALL:
  - select the winner by round-robin, searching from index ptr+1 upward and wrapping modulo NREQ;
  - latch its opcode into op_q and its index into id_q;
  - set gnt_pad to one-hot(winner);
  - go to ISSUE.
REQ-019 In IDLE with no request, the block SHALL stay in IDLE with gnt_pad at 0.
REQ-020 dec_in_pad SHALL equal op_q at all times.
REQ-021 In ISSUE, at the next edge the block SHALL:
  - capture dec_out_pad into rsp_dat_pad;
  - copy id_q into rsp_id_pad;
  - set rsp_vld_pad to 1;
  - clear gnt_pad;
  - go to HOLD.
REQ-022 gnt_pad SHALL be high for exactly one cycle per grant, namely the ISSUE cycle.
REQ-023 Latency SHALL be fixed:
  - request sampled at edge E;
  - gnt_pad high in cycle E..E+1;
  - rsp_vld_pad high from edge E+1.
REQ-024 In HOLD, rsp_vld_pad, rsp_id_pad and rsp_dat_pad SHALL hold stable until rsp_rdy_pad is sampled high.
REQ-025 On the HOLD edge where rsp_rdy_pad is high, the block SHALL:
  - set rsp_vld_pad to 0;
  - set ptr to id_q;
  - increment cnt_pad by 1, wrapping 255 to 0;
  - go to IDLE.
REQ-026 Minimum issue spacing SHALL be 3 cycles (IDLE, ISSUE, HOLD); the block SHALL never return directly from HOLD to ISSUE.
REQ-027 req_pad and op_pad SHALL be ignored in ISSUE and HOLD.
REQ-028 A requester dropping its request before it is sampled in IDLE SHALL NOT be granted.
REQ-029 The opcode SHALL be sampled only on the grant-decision edge; later changes to op_pad SHALL NOT affect the result.
REQ-030 rsp_rdy_pad SHALL be ignored outside HOLD.
REQ-031 When several requests are set simultaneously, the block SHALL grant only the first requester in round-robin order; the others SHALL wait for a later IDLE.
REQ-032 A requester that holds its request continuously SHALL be granted within NREQ grants.

Reset
REQ-033 While rst_pad is high, the block SHALL immediately set, independent of clk_pad:
  - state to IDLE;
  - gnt_pad, op_q (and thus dec_in_pad), id_q, rsp_vld_pad, rsp_id_pad, rsp_dat_pad and cnt_pad to 0;
  - ptr to NREQ-1, giving requester 0 first priority.
REQ-034 Reset asserted in ISSUE or HOLD SHALL abort the transaction without producing a response and without incrementing cnt_pad.
REQ-035 After rst_pad deasserts, the first rising edge SHALL be able to grant.

Verification
REQ-036 Single request: req_pad=0001, op slice0=0x0A5, rsp_rdy_pad=1 -> gnt_pad=0001 for 1 cycle; rsp_vld_pad at E+1 with rsp_id_pad=0 and rsp_dat_pad = decoder(0x0A5); cnt_pad=1.
REQ-037 All four requesting continuously with rsp_rdy_pad=1 -> grants in order 0,1,2,3,0; spacing of exactly 3 cycles; cnt_pad=5 after 5 responses.
REQ-038 Backpressure: rsp_rdy_pad low for 10 cycles -> rsp_* outputs stable, no new gnt_pad, busy_pad=1; after rsp_rdy_pad=1, return to IDLE on the next edge.
REQ-039 Wrap: 256 completed responses -> cnt_pad reads 0.
REQ-040 Reset mid-HOLD -> rsp_vld_pad drops asynchronously, cnt_pad=0, next grant goes to requester 0 when req_pad=1111.
REQ-041 op_pad changed in the ISSUE cycle -> rsp_dat_pad reflects the opcode sampled at the grant edge.
